// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame controller: FSM state
// encoding and default frame geometry.
package uart_rx_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops
// reset to the idle (high) line level so reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Oversampled UART receive framer: start qualification, LSB-first data
// capture, stop-bit sampling. Optional even parity with UART_RX_PARITY_EN.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 baud_tick_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid_out,
    output logic                 stop_bit_out,
    output logic                 stopbit_check_enable_out,
    output logic                 parity_err_out,
    output logic                 busy_out
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    state_e               state;
    logic [CNT_W-1:0]     count;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit;
`endif

    uart_rx_sync u_sync (
        .clk   (Clk),
        .reset (reset),
        .rx    (rx_in),
        .rx_s  (rx_s)
    );

    assign busy_out = (state != ST_IDLE);

    // Every branch that leaves a state also clears count, so each state
    // measures its own sample point from the tick it was entered on.
    always_ff @(posedge Clk) begin
        data_valid_out           <= 1'b0;
        stopbit_check_enable_out <= 1'b0;
        if (reset) begin
            state        <= ST_IDLE;
            count        <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            data_out     <= '0;
            stop_bit_out <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_bit     <= 1'b0;
            parity_err_out <= 1'b0;
`endif
        end else if (baud_tick_in) begin
            count <= count + 1'b1;
            case (state)
                ST_IDLE: begin
                    count <= '0;
                    if (!rx_s) state <= ST_START;
                end
                ST_START: begin
                    if (count == MID_CNT) begin
                        count   <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (count == LAST_CNT) begin
                        count   <= '0;
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (count == LAST_CNT) begin
                        count      <= '0;
                        parity_bit <= rx_s;
                        state      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (count == LAST_CNT) begin
                        count                    <= '0;
                        stop_bit_out             <= rx_s;
                        data_out                 <= shift;
                        data_valid_out           <= 1'b1;
                        stopbit_check_enable_out <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_out <= (^shift) ^ parity_bit;
`endif
                        // A low stop bit may be a break; wait for the line to recover.
                        state <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    count <= '0;
                    if (rx_s) state <= ST_IDLE;
                end
                default: begin
                    count <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl; honours UART_RX_PARITY_EN.
module tb_uart_rx_frame_ctrl;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          Clk;
    logic          reset;
    logic          rx_in;
    logic          baud_tick_in;
    logic [DB-1:0] data_out;
    logic          data_valid_out;
    logic          stop_bit_out;
    logic          stopbit_check_enable_out;
    logic          parity_err_out;
    logic          busy_out;

    uart_rx_frame_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .Clk                      (Clk),
        .reset                    (reset),
        .rx_in                    (rx_in),
        .baud_tick_in             (baud_tick_in),
        .data_out                 (data_out),
        .data_valid_out           (data_valid_out),
        .stop_bit_out             (stop_bit_out),
        .stopbit_check_enable_out (stopbit_check_enable_out),
        .parity_err_out           (parity_err_out),
        .busy_out                 (busy_out)
    );

    // clock / tick generation
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int tick_div   = 1;
    int phase      = 0;
    int tick_count = 0;

    // observation state: {parity_err, stop_bit, data}
    logic [DB+1:0] exp_q[$];
    logic [DB+1:0] obs_q[$];
    int valid_cycles = 0;
    int en_cycles    = 0;
    int en_mismatch  = 0;
    int freeze_viol  = 0;
    logic last_busy  = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Monitor, then drive the tick for the next posedge (inputs seen at the
    // previous posedge are still on the wires here).
    always @(negedge Clk) begin
        if (baud_tick_in) tick_count++;
        else if (!reset && busy_out !== last_busy) freeze_viol++;
        last_busy = busy_out;
        if (data_valid_out) begin
            valid_cycles++;
            obs_q.push_back({parity_err_out, stop_bit_out, data_out});
        end
        if (stopbit_check_enable_out) en_cycles++;
        if (data_valid_out !== stopbit_check_enable_out) en_mismatch++;
        baud_tick_in = (phase == 0);
        phase = (phase + 1) % tick_div;
    end

    // behavioural reference: a well-timed frame yields its word and stop level
    function automatic logic [DB+1:0] model_frame(input logic [DB-1:0] d, input logic stop, input logic pbit);
        logic perr;
`ifdef UART_RX_PARITY_EN
        perr = (^d) ^ pbit;
`else
        perr = 1'b0;
        if (pbit) perr = 1'b0;
`endif
        return {perr, stop, d};
    endfunction

    // driver tasks
    task automatic wait_ticks(input int n);
        int target;
        target = tick_count + n;
        while (tick_count < target) begin
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic pbit);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(pbit);
`endif
        send_bit(stop);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        valid_cycles = 0;
        en_cycles    = 0;
        en_mismatch  = 0;
        freeze_viol  = 0;
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (3) begin @(negedge Clk); #1; end
        total_cnt++;
        if (data_out !== '0) $display("FAIL reset_data: got %h want 00", data_out); else pass_cnt++;
        total_cnt++;
        if (data_valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_valid_out); else pass_cnt++;
        total_cnt++;
        if (stop_bit_out !== 1'b1) $display("FAIL reset_stop: got %b want 1", stop_bit_out); else pass_cnt++;
        total_cnt++;
        if (stopbit_check_enable_out !== 1'b0) $display("FAIL reset_en: got %b want 0", stopbit_check_enable_out); else pass_cnt++;
        total_cnt++;
        if (parity_err_out !== 1'b0) $display("FAIL reset_perr: got %b want 0", parity_err_out); else pass_cnt++;
        total_cnt++;
        if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_out); else pass_cnt++;
        reset = 1'b0;
        wait_ticks(20);
    endtask

    task automatic test_basic();
        clear_obs();
        tick_div = 1;
        send_frame(8'h55, 1'b1, 1'b0);
        wait_ticks(4);
        total_cnt++;
        if (valid_cycles !== 1) $display("FAIL basic_valid_cycles: got %0d want 1", valid_cycles); else pass_cnt++;
        total_cnt++;
        if (en_cycles !== 1 || en_mismatch !== 0)
            $display("FAIL basic_enable: got cycles=%0d skew=%0d want 1/0", en_cycles, en_mismatch);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != 1 || obs_q[0] !== model_frame(8'h55, 1'b1, 1'b0))
            $display("FAIL basic_word: got n=%0d want {0,1,55}", obs_q.size());
        else pass_cnt++;
        total_cnt++;
        if (data_out !== 8'h55 || stop_bit_out !== 1'b1)
            $display("FAIL basic_hold: got %h/%b want 55/1", data_out, stop_bit_out);
        else pass_cnt++;
    endtask

    task automatic test_false_start();
        clear_obs();
        rx_in = 1'b0;
        wait_ticks(4);
        rx_in = 1'b1;
        wait_ticks(1);
        total_cnt++;
        if (busy_out !== 1'b1) $display("FAIL false_start_busy_start: got %b want 1", busy_out); else pass_cnt++;
        wait_ticks(OS / 2 + 4);
        total_cnt++;
        if (busy_out !== 1'b0) $display("FAIL false_start_idle: got %b want 0", busy_out); else pass_cnt++;
        total_cnt++;
        if (valid_cycles !== 0 || en_cycles !== 0)
            $display("FAIL false_start_strobes: got valid=%0d en=%0d want 0/0", valid_cycles, en_cycles);
        else pass_cnt++;
        wait_ticks(OS);
    endtask

    task automatic test_framing();
        clear_obs();
        send_frame(8'hA3, 1'b0, 1'b0);
        wait_ticks(2);
        total_cnt++;
        if (obs_q.size() != 1 || obs_q[0] !== model_frame(8'hA3, 1'b0, 1'b0))
            $display("FAIL framing_word: got n=%0d data=%h want A3 stop 0", obs_q.size(), data_out);
        else pass_cnt++;
        total_cnt++;
        if (en_cycles !== 1 || stop_bit_out !== 1'b0)
            $display("FAIL framing_stop: got en=%0d stop=%b want 1/0", en_cycles, stop_bit_out);
        else pass_cnt++;
        // line stays low: a new start must not be taken
        wait_ticks(3 * OS);
        total_cnt++;
        if (busy_out !== 1'b1 || valid_cycles !== 1)
            $display("FAIL framing_wait_high: got busy=%b valid=%0d want 1/1", busy_out, valid_cycles);
        else pass_cnt++;
        rx_in = 1'b1;
        wait_ticks(4);
        total_cnt++;
        if (busy_out !== 1'b0) $display("FAIL framing_recover: got %b want 0", busy_out); else pass_cnt++;
        wait_ticks(OS);
    endtask

    task automatic test_reset_mid();
        clear_obs();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        repeat (2) begin @(negedge Clk); #1; end
        total_cnt++;
        if (data_out !== '0 || stop_bit_out !== 1'b1 || busy_out !== 1'b0 || parity_err_out !== 1'b0)
            $display("FAIL reset_mid_outputs: got data=%h stop=%b busy=%b perr=%b want 00/1/0/0",
                     data_out, stop_bit_out, busy_out, parity_err_out);
        else pass_cnt++;
        reset = 1'b0;
        rx_in = 1'b1;
        wait_ticks(2 * OS);
        total_cnt++;
        if (valid_cycles !== 0 || en_cycles !== 0)
            $display("FAIL reset_mid_no_strobe: got valid=%0d en=%0d want 0/0", valid_cycles, en_cycles);
        else pass_cnt++;
        send_frame(8'h0F, 1'b1, 1'b0);
        wait_ticks(4);
        total_cnt++;
        if (obs_q.size() != 1 || obs_q[0] !== model_frame(8'h0F, 1'b1, 1'b0))
            $display("FAIL reset_mid_next_frame: got n=%0d data=%h want 0F", obs_q.size(), data_out);
        else pass_cnt++;
    endtask

    task automatic test_slow_tick();
        clear_obs();
        tick_div = 3;
        wait_ticks(2);
        freeze_viol = 0;
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_ticks(4);
        total_cnt++;
        if (obs_q.size() != 1 || obs_q[0] !== model_frame(8'h3C, 1'b1, 1'b0))
            $display("FAIL slow_tick_word: got n=%0d data=%h want 3C", obs_q.size(), data_out);
        else pass_cnt++;
        total_cnt++;
        if (freeze_viol !== 0) $display("FAIL slow_tick_frozen: got %0d changes want 0", freeze_viol); else pass_cnt++;
        tick_div = 1;
        wait_ticks(4);
    endtask

    task automatic run_frames(input int n, input bit random_gaps);
        logic [DB-1:0] d;
        logic stop;
        logic pbit;
        int gap;
        for (int i = 0; i < n; i++) begin
            d    = DB'($urandom_range(0, (1 << DB) - 1));
            stop = random_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            pbit = 1'($urandom_range(0, 1));
            if (random_gaps) begin
                tick_div = $urandom_range(1, 3);
                wait_ticks(2);
            end
            exp_q.push_back(model_frame(d, stop, pbit));
            send_frame(d, stop, pbit);
            rx_in = 1'b1;
            gap = !random_gaps ? 0 : (stop ? $urandom_range(0, 6) : $urandom_range(4, 8));
            if (gap > 0) wait_ticks(gap);
        end
        wait_ticks(4);
        tick_div = 1;
    endtask

    task automatic test_back_to_back();
        clear_obs();
        run_frames(4, 1'b0);
        total_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_frame%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (en_cycles !== exp_q.size() || en_mismatch !== 0)
            $display("FAIL b2b_enable: got cycles=%0d skew=%0d want %0d/0", en_cycles, en_mismatch, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_random();
        clear_obs();
        run_frames(12, 1'b1);
        total_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL random_frame%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (valid_cycles !== exp_q.size() || en_cycles !== exp_q.size() || en_mismatch !== 0)
            $display("FAIL random_strobes: got valid=%0d en=%0d skew=%0d want %0d each, skew 0",
                     valid_cycles, en_cycles, en_mismatch, exp_q.size());
        else pass_cnt++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_obs();
        send_frame(8'h07, 1'b1, 1'b0);
        wait_ticks(2);
        total_cnt++;
        if (parity_err_out !== 1'b1) $display("FAIL parity_bad: got %b want 1", parity_err_out); else pass_cnt++;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_ticks(2);
        total_cnt++;
        if (parity_err_out !== 1'b0) $display("FAIL parity_good: got %b want 0", parity_err_out); else pass_cnt++;
    endtask
`endif

    initial begin
        rx_in        = 1'b1;
        reset        = 1'b1;
        baud_tick_in = 1'b0;
        test_reset();
        test_basic();
        test_false_start();
        test_framing();
        test_reset_mid();
        test_slow_tick();
        test_back_to_back();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter OVERSAMPLE, default 16, baud ticks per bit period; even, >= 4.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; 5..9.
REQ-003 Port Clk  input  1  system clock; all logic on posedge Clk.
REQ-004 Port reset  input  1  reset; synchronous, active-high.
REQ-005 Port rx_in  input  1  asynchronous serial line, idle high.
REQ-006 Port baud_tick_in  input  1  one-Clk-wide pulse at OVERSAMPLE x baud rate.
REQ-007 Port data_out  output  DATA_BITS  received word, LSB first on line.
REQ-008 Port data_valid_out  output  1  one-cycle pulse; data_out is valid.
REQ-009 Port stop_bit_out  output  1  sampled stop-bit level, feeds the stop-bit checker.
REQ-010 Port stopbit_check_enable_out  output  1  one-cycle strobe qualifying stop_bit_out.
REQ-011 Port parity_err_out  output  1  parity mismatch flag, valid with data_valid_out.
REQ-012 Port busy_out  output  1  high in any state other than IDLE.

Function
REQ-013 rx_in SHALL pass through a 2-flop synchronizer; the FSM sees only the synchronized value rx_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-015 Tick counter SHALL advance only on baud_tick_in; it clears on every state transition.
REQ-016 IDLE: on a tick with rx_s==0, go to START.
REQ-017 START: on the tick where count==OVERSAMPLE/2-1, sample rx_s; 0 -> DATA, 1 -> IDLE (false start, no outputs).
REQ-018 DATA: on each tick where count==OVERSAMPLE-1, shift rx_s into the MSB of the shift register (LSB-first frame); after DATA_BITS samples go to PARITY or STOP.
REQ-019 STOP: on the tick where count==OVERSAMPLE-1, sample rx_s into stop_bit_out.
REQ-020 On the Clk cycle after the STOP sample: data_out updated, data_valid_out=1, stopbit_check_enable_out=1, each for exactly one cycle.
REQ-021 data_out and stop_bit_out SHALL hold their value until the next frame completes.
REQ-022 After STOP: stop sample 1 -> IDLE; stop sample 0 (framing error or break) -> WAIT_HIGH.
REQ-023 WAIT_HIGH: stay until rx_s==1 on a tick, then go to IDLE; no new start is accepted while in WAIT_HIGH.
REQ-024 Cycles without baud_tick_in SHALL not change state, counter, or shift register.
REQ-025 busy_out SHALL be combinational from state: 0 in IDLE, 1 otherwise.

Reset
REQ-026 While reset==1 at posedge Clk: state=IDLE, counter=0, shift register=0, synchronizer flops=1.
REQ-027 Reset values: data_out=0, data_valid_out=0, stop_bit_out=1, stopbit_check_enable_out=0, parity_err_out=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no valid or enable strobe.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined: PARITY state follows DATA and samples one bit at count==OVERSAMPLE-1.
REQ-030 With the macro defined: parity_err_out = XOR(data bits, parity bit) under even parity, registered with data_valid_out.
REQ-031 Without the macro: no PARITY state; DATA goes directly to STOP; parity_err_out is tied to 0.

Structure
REQ-032 Package uart_rx_pkg SHALL hold the state enum typedef and the default OVERSAMPLE and DATA_BITS constants.
REQ-033 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer with reset value 1.

Verification
REQ-034 baud_tick_in tied high; frame start, 0x55 LSB first, stop=1, 16 Clk per bit -> data_out=0x55, one data_valid_out pulse, stop_bit_out=1 with a one-cycle enable strobe.
REQ-035 rx low for 4 ticks, then high -> returns to IDLE; no data_valid_out; busy_out drops after the START sample.
REQ-036 Frame 0xA3 with stop=0 -> data_out=0xA3, stop_bit_out=0 with enable strobe; FSM in WAIT_HIGH until rx returns high; a second start during the low level is ignored.
REQ-037 reset asserted mid-DATA of frame 0xFF -> all outputs return to reset values; the next clean frame 0x0F is received correctly.
REQ-038 UART_RX_PARITY_EN defined; 0x07 with parity bit 0 -> parity_err_out=1; 0x07 with parity bit 1 -> parity_err_out=0.
REQ-039 baud_tick_in every 3rd cycle, frame 0x3C at 16 ticks per bit -> data_out=0x3C; state frozen on non-tick cycles.
